// File: rtl/hamming_log_pkg.sv
// -----------------------------------------------------------------------------
// hamming_log_pkg
// Shared definitions for the Hamming event logger:
//   - per-block syndrome values that point at a data bit or a parity bit
//   - logger FSM state encoding
//   - default-width event record
//   - classify_block(): maps one 3-bit block syndrome to {is_data, is_parity}
// Optional build macro seen by users of this package: HAMMING_LOG_TIMESTAMP_EN
// -----------------------------------------------------------------------------
package hamming_log_pkg;

    // Syndromes that locate a flipped data bit inside a 4-bit block.
    localparam logic [2:0] SYN_DATA_3 = 3'b011;
    localparam logic [2:0] SYN_DATA_5 = 3'b101;
    localparam logic [2:0] SYN_DATA_6 = 3'b110;
    localparam logic [2:0] SYN_DATA_7 = 3'b111;

    // Single-bit syndromes locate a flipped parity bit.
    localparam logic [2:0] SYN_PAR_1  = 3'b001;
    localparam logic [2:0] SYN_PAR_2  = 3'b010;
    localparam logic [2:0] SYN_PAR_4  = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        HOLD = 2'd2
    } log_state_e;

    localparam int DEF_WIDTH       = 64;
    localparam int DEF_BLOCKS      = DEF_WIDTH / 4;
    localparam int DEF_PARITY_BITS = DEF_BLOCKS * 3;

    // Event record at the default geometry. The top re-declares the same
    // shape against its own parameters so non-default widths still work.
    typedef struct packed {
        logic [DEF_WIDTH-1:0]       cnt;
        logic [DEF_PARITY_BITS-1:0] syn;
        logic [DEF_BLOCKS-1:0]      data_mask;
        logic [DEF_BLOCKS-1:0]      parity_mask;
    } event_rec_t;

    // Returns {is_data, is_parity}; 000 and anything else give 2'b00.
    function automatic logic [1:0] classify_block(input logic [2:0] syn);
        logic [1:0] cls;
        cls = 2'b00;
        case (syn)
            SYN_DATA_3, SYN_DATA_5, SYN_DATA_6, SYN_DATA_7: cls = 2'b10;
            SYN_PAR_1, SYN_PAR_2, SYN_PAR_4:                cls = 2'b01;
            default:                                        cls = 2'b00;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/hamming_log_fifo.sv
// -----------------------------------------------------------------------------
// hamming_log_fifo
// Synchronous DEPTH-entry FIFO holding event records. Head is read
// combinationally from storage; push and pop may both happen on the same
// edge, including when full (level stays at DEPTH).
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   push, wdata   write request and data (ignored when full without a pop)
//   pop           read request (ignored when empty)
//   rdata         head entry
//   level         number of stored entries, 0..DEPTH
//   full, empty   level == DEPTH / level == 0
// -----------------------------------------------------------------------------
module hamming_log_fifo #(
    parameter  int DW    = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push_ok;
    logic          pop_ok;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem_q[rptr_q];

    // A push into a full FIFO is legal only when the head leaves this cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push_ok) wptr_d = wptr_q + AW'(1);
        if (pop_ok)  rptr_d = rptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            if (push_ok) mem_q[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/hamming_event_log.sv
// -----------------------------------------------------------------------------
// hamming_event_log
// Observes the correction phase of the Hamming-protected counter and turns
// each error episode (error_detected && !enable) into exactly one event
// record, classifying each 4-bit block as a data-bit or parity-bit error.
// Records queue in hamming_log_fifo and drain over a valid/ready port.
// Saturating statistics count pushed and dropped episodes.
//
// Optional macro HAMMING_LOG_TIMESTAMP_EN adds a free-running 32-bit cycle
// counter, latched with each snapshot and presented as ev_timestamp.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   enable                   counter-stage enable (logging only while low)
//   error_detected           error flag from the counter stage
//   syndrome, counter        correction-phase syndrome and counter value
//   clr_stats                one-cycle pulse clearing the statistics
//   ev_valid / ev_ready      head event handshake
//   ev_counter, ev_syndrome  head event snapshot
//   ev_data_mask             per-block data-bit error flags of head event
//   ev_parity_mask           per-block parity-bit error flags of head event
//   fifo_level               queued entries
//   event_count, drop_count  saturating push / drop counters
//   overflow                 sticky, set on first drop
//   ev_timestamp             (macro only) head event cycle stamp
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for error_detected && !enable; snapshot taken on entry
// PUSH  | one cycle: classify snapshot, write to FIFO or drop if full
// HOLD  | swallow the rest of the episode until the start condition drops
// -----------------------------------------------------------------------------
module hamming_event_log
    import hamming_log_pkg::*;
#(
    parameter int WIDTH       = 64,
    parameter int BLOCKS      = WIDTH / 4,
    parameter int PARITY_BITS = BLOCKS * 3,
    parameter int DEPTH       = 4,
    parameter int CNT_W       = 16,
    localparam int LW         = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   error_detected,
    input  logic [PARITY_BITS-1:0] syndrome,
    input  logic [WIDTH-1:0]       counter,
    input  logic                   clr_stats,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [WIDTH-1:0]       ev_counter,
    output logic [PARITY_BITS-1:0] ev_syndrome,
    output logic [BLOCKS-1:0]      ev_data_mask,
    output logic [BLOCKS-1:0]      ev_parity_mask,
    output logic [LW-1:0]          fifo_level,
    output logic [CNT_W-1:0]       event_count,
    output logic [CNT_W-1:0]       drop_count,
    output logic                   overflow
`ifdef HAMMING_LOG_TIMESTAMP_EN
    ,
    output logic [31:0]            ev_timestamp
`endif
);

    typedef struct packed {
`ifdef HAMMING_LOG_TIMESTAMP_EN
        logic [31:0]            ts;
`endif
        logic [WIDTH-1:0]       cnt;
        logic [PARITY_BITS-1:0] syn;
        logic [BLOCKS-1:0]      data_mask;
        logic [BLOCKS-1:0]      parity_mask;
    } ev_rec_t;

    localparam int REC_W = $bits(ev_rec_t);

    log_state_e             state_q, state_d;
    logic [WIDTH-1:0]       snap_cnt_q, snap_cnt_d;
    logic [PARITY_BITS-1:0] snap_syn_q, snap_syn_d;
    logic [CNT_W-1:0]       event_count_q, event_count_d;
    logic [CNT_W-1:0]       drop_count_q, drop_count_d;
    logic                   overflow_q, overflow_d;

    logic                   start;
    logic                   push_req;
    logic                   push_ok;
    logic                   drop;
    logic                   pop_fire;
    logic [BLOCKS-1:0]      data_mask;
    logic [BLOCKS-1:0]      parity_mask;
    ev_rec_t                wr_rec;
    ev_rec_t                head;
    logic [REC_W-1:0]       fifo_rdata;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign start    = error_detected && !enable;
    assign push_req = (state_q == PUSH);

    // ev_valid depends only on stored level, never on ev_ready.
    assign ev_valid = !fifo_empty;
    assign pop_fire = ev_valid && ev_ready;
    assign push_ok  = push_req && (!fifo_full || pop_fire);
    assign drop     = push_req && fifo_full && !pop_fire;

    always_comb begin
        data_mask   = '0;
        parity_mask = '0;
        for (int i = 0; i < BLOCKS; i++) begin
            {data_mask[i], parity_mask[i]} = classify_block(snap_syn_q[3*i +: 3]);
        end
    end

    always_comb begin
        state_d    = state_q;
        snap_cnt_d = snap_cnt_q;
        snap_syn_d = snap_syn_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_cnt_d = counter;
                    snap_syn_d = syndrome;
                    state_d    = PUSH;
                end
            end
            // Unconditional: a rising enable here must not lose the event.
            PUSH:    state_d = HOLD;
            HOLD:    if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        event_count_d = event_count_q;
        drop_count_d  = drop_count_q;
        overflow_d    = overflow_q;
        if (clr_stats) begin
            event_count_d = '0;
            drop_count_d  = '0;
            overflow_d    = 1'b0;
        end else begin
            if (push_ok && (event_count_q != '1)) event_count_d = event_count_q + CNT_W'(1);
            if (drop && (drop_count_q != '1))     drop_count_d  = drop_count_q + CNT_W'(1);
            if (drop)                             overflow_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            snap_cnt_q    <= '0;
            snap_syn_q    <= '0;
            event_count_q <= '0;
            drop_count_q  <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            snap_cnt_q    <= snap_cnt_d;
            snap_syn_q    <= snap_syn_d;
            event_count_q <= event_count_d;
            drop_count_q  <= drop_count_d;
            overflow_q    <= overflow_d;
        end
    end

`ifdef HAMMING_LOG_TIMESTAMP_EN
    logic [31:0] ts_q, ts_d;
    logic [31:0] snap_ts_q, snap_ts_d;

    assign ts_d      = ts_q + 32'd1;
    assign snap_ts_d = ((state_q == IDLE) && start) ? ts_q : snap_ts_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q      <= '0;
            snap_ts_q <= '0;
        end else begin
            ts_q      <= ts_d;
            snap_ts_q <= snap_ts_d;
        end
    end

    assign wr_rec.ts     = snap_ts_q;
    assign ev_timestamp  = ev_valid ? head.ts : '0;
`endif

    assign wr_rec.cnt         = snap_cnt_q;
    assign wr_rec.syn         = snap_syn_q;
    assign wr_rec.data_mask   = data_mask;
    assign wr_rec.parity_mask = parity_mask;

    hamming_log_fifo #(
        .DW    (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_ok),
        .wdata (wr_rec),
        .pop   (pop_fire),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head = fifo_rdata;

    // Head fields read as zero whenever the FIFO is empty.
    assign ev_counter     = ev_valid ? head.cnt         : '0;
    assign ev_syndrome    = ev_valid ? head.syn         : '0;
    assign ev_data_mask   = ev_valid ? head.data_mask   : '0;
    assign ev_parity_mask = ev_valid ? head.parity_mask : '0;

    assign event_count = event_count_q;
    assign drop_count  = drop_count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_hamming_event_log.sv
module tb_hamming_event_log;

    localparam int WIDTH   = 64;
    localparam int BLOCKS  = 16;
    localparam int PB      = 48;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 4;
    localparam int LW      = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic              error_detected = 1'b0;
    logic [PB-1:0]     syndrome = '0;
    logic [WIDTH-1:0]  counter = '0;
    logic              clr_stats = 1'b0;
    logic              ev_ready = 1'b0;
    logic              ev_valid;
    logic [WIDTH-1:0]  ev_counter;
    logic [PB-1:0]     ev_syndrome;
    logic [BLOCKS-1:0] ev_data_mask;
    logic [BLOCKS-1:0] ev_parity_mask;
    logic [LW-1:0]     fifo_level;
    logic [CNT_W-1:0]  event_count;
    logic [CNT_W-1:0]  drop_count;
    logic              overflow;
`ifdef HAMMING_LOG_TIMESTAMP_EN
    logic [31:0]       ev_timestamp;
`endif

    always #5 clk = ~clk;

    hamming_event_log #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .error_detected (error_detected),
        .syndrome       (syndrome),
        .counter        (counter),
        .clr_stats      (clr_stats),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_counter     (ev_counter),
        .ev_syndrome    (ev_syndrome),
        .ev_data_mask   (ev_data_mask),
        .ev_parity_mask (ev_parity_mask),
        .fifo_level     (fifo_level),
        .event_count    (event_count),
        .drop_count     (drop_count),
        .overflow       (overflow)
`ifdef HAMMING_LOG_TIMESTAMP_EN
        ,
        .ev_timestamp   (ev_timestamp)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: queue of expected records plus plain-integer stats.
    typedef struct {
        logic [63:0] cnt;
        logic [47:0] syn;
        logic [15:0] dm;
        logic [15:0] pm;
        logic [31:0] ts;
    } rec_t;

    rec_t        exp_q[$];
    rec_t        snap;
    bit          m_busy = 0;
    bit          m_push_pending = 0;
    int          m_ev = 0;
    int          m_dr = 0;
    bit          m_ov = 0;
    logic [31:0] m_ts = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void calc_masks(input logic [47:0] s, output logic [15:0] dm,
                                       output logic [15:0] pm);
        int v;
        dm = '0;
        pm = '0;
        for (int i = 0; i < 16; i++) begin
            v = int'((s >> (3 * i)) & 48'd7);
            dm[i] = (v == 3) || (v == 5) || (v == 6) || (v == 7);
            pm[i] = (v == 1) || (v == 2) || (v == 4);
        end
    endfunction

    task automatic check_all();
        chk("ev_valid", 64'(ev_valid), 64'(exp_q.size() != 0));
        chk("fifo_level", 64'(fifo_level), 64'(exp_q.size()));
        chk("event_count", 64'(event_count), 64'(m_ev));
        chk("drop_count", 64'(drop_count), 64'(m_dr));
        chk("overflow", 64'(overflow), 64'(m_ov));
        if (exp_q.size() != 0) begin
            chk("ev_counter", ev_counter, exp_q[0].cnt);
            chk("ev_syndrome", 64'(ev_syndrome), 64'(exp_q[0].syn));
            chk("ev_data_mask", 64'(ev_data_mask), 64'(exp_q[0].dm));
            chk("ev_parity_mask", 64'(ev_parity_mask), 64'(exp_q[0].pm));
`ifdef HAMMING_LOG_TIMESTAMP_EN
            chk("ev_timestamp", 64'(ev_timestamp), 64'(exp_q[0].ts));
`endif
        end
    endtask

    // Advance one clock: update the model from the inputs present before the
    // edge, then compare 1 time unit after the edge.
    task automatic step();
        bit start;
        bit pop;
        bit dpush;
        bit ddrop;
        rec_t r;
        start = error_detected && !enable;
        pop   = (exp_q.size() != 0) && ev_ready;
        dpush = 0;
        ddrop = 0;
        if (m_push_pending) begin
            if (exp_q.size() < DEPTH || pop) dpush = 1;
            else                             ddrop = 1;
            m_push_pending = 0;
        end else if (m_busy) begin
            if (!start) m_busy = 0;
        end else if (start) begin
            snap.cnt = counter;
            snap.syn = syndrome;
            snap.ts  = m_ts;
            m_busy = 1;
            m_push_pending = 1;
        end
        if (pop) void'(exp_q.pop_front());
        if (dpush) begin
            r = snap;
            calc_masks(r.syn, r.dm, r.pm);
            exp_q.push_back(r);
        end
        if (clr_stats) begin
            m_ev = 0;
            m_dr = 0;
            m_ov = 0;
        end else begin
            if (dpush && m_ev < CNT_MAX) m_ev++;
            if (ddrop && m_dr < CNT_MAX) m_dr++;
            if (ddrop) m_ov = 1;
        end
        m_ts = m_ts + 32'd1;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #2;
        chk("rst_ev_valid", 64'(ev_valid), 64'd0);
        chk("rst_ev_counter", ev_counter, 64'd0);
        chk("rst_ev_syndrome", 64'(ev_syndrome), 64'd0);
        chk("rst_data_mask", 64'(ev_data_mask), 64'd0);
        chk("rst_parity_mask", 64'(ev_parity_mask), 64'd0);
        chk("rst_fifo_level", 64'(fifo_level), 64'd0);
        chk("rst_event_count", 64'(event_count), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
`ifdef HAMMING_LOG_TIMESTAMP_EN
        chk("rst_ev_timestamp", 64'(ev_timestamp), 64'd0);
`endif
        exp_q.delete();
        m_busy = 0;
        m_push_pending = 0;
        m_ev = 0;
        m_dr = 0;
        m_ov = 0;
        m_ts = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // One short episode: start for one cycle, then quiet long enough to idle.
    task automatic episode(input logic [47:0] syn, input logic [63:0] cnt);
        syndrome = syn;
        counter = cnt;
        error_detected = 1'b1;
        step();
        error_detected = 1'b0;
        counter = ~cnt;
        repeat (2) step();
    endtask

    task automatic drain();
        ev_ready = 1'b1;
        repeat (DEPTH + 2) step();
        ev_ready = 1'b0;
    endtask

    logic [63:0] cval;

    initial begin
        #2;
        apply_reset();

        // Long episode, block 0 = 011: exactly one event, 2-cycle latency.
        syndrome = 48'h3;
        counter = 64'h0123_4567_89ab_cdef;
        error_detected = 1'b1;
        step();
        chk("lat_edge_n", 64'(ev_valid), 64'd0);
        step();
        chk("lat_edge_n1", 64'(ev_valid), 64'd1);
        repeat (3) step();
        error_detected = 1'b0;
        repeat (3) step();
        chk("one_event_level", 64'(fifo_level), 64'd1);
        chk("blk0_data_mask", 64'(ev_data_mask), 64'h1);
        chk("blk0_parity_mask", 64'(ev_parity_mask), 64'h0);
        drain();

        // Block 2 = 100, block 5 = 111; counter changes after the start cycle.
        cval = 64'hdead_beef_cafe_f00d;
        syndrome = (48'd4 << 6) | (48'd7 << 15);
        counter = cval;
        error_detected = 1'b1;
        step();
        counter = 64'h1111_2222_3333_4444;
        repeat (2) step();
        error_detected = 1'b0;
        repeat (2) step();
        chk("snap_counter", ev_counter, cval);
        chk("blk25_parity_mask", 64'(ev_parity_mask), 64'h0004);
        chk("blk25_data_mask", 64'(ev_data_mask), 64'h0020);
        drain();

        // Fill to overflow with ready low.
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) episode(48'(i + 1), 64'(100 + i));
        chk("full_level", 64'(fifo_level), 64'(DEPTH));
        chk("full_drop_count", 64'(drop_count), 64'd2);
        chk("full_overflow", 64'(overflow), 64'd1);
        chk("full_event_count", 64'(event_count), 64'(DEPTH));
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        chk("clr_event_count", 64'(event_count), 64'd0);
        chk("clr_drop_count", 64'(drop_count), 64'd0);
        chk("clr_overflow", 64'(overflow), 64'd0);
        chk("clr_keeps_level", 64'(fifo_level), 64'(DEPTH));

        // Full FIFO: push and pop on the same edge.
        syndrome = 48'h5;
        counter = 64'h77;
        error_detected = 1'b1;
        step();
        error_detected = 1'b0;
        ev_ready = 1'b1;
        step();
        ev_ready = 1'b0;
        step();
        chk("pushpop_level", 64'(fifo_level), 64'(DEPTH));
        chk("pushpop_no_drop", 64'(drop_count), 64'd0);
        drain();

        // Enable high suppresses logging; zero syndrome still logs.
        enable = 1'b1;
        syndrome = 48'h7;
        error_detected = 1'b1;
        repeat (3) step();
        error_detected = 1'b0;
        step();
        chk("enable_blocks", 64'(fifo_level), 64'd0);
        enable = 1'b0;
        episode(48'h0, 64'h55);
        chk("zero_syn_level", 64'(fifo_level), 64'd1);
        chk("zero_syn_dmask", 64'(ev_data_mask), 64'd0);
        chk("zero_syn_pmask", 64'(ev_parity_mask), 64'd0);
        drain();

        // Reset while in HOLD with two entries queued.
        episode(48'h9, 64'h901);
        syndrome = 48'h2;
        counter = 64'h902;
        error_detected = 1'b1;
        repeat (4) step();
        chk("prereset_level", 64'(fifo_level), 64'd2);
        error_detected = 1'b0;
        apply_reset();
        check_all();
        episode(48'h3 << 9, 64'habc);
        chk("post_reset_level", 64'(fifo_level), 64'd1);
        chk("post_reset_dmask", 64'(ev_data_mask), 64'h0008);
        drain();

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            logic [47:0] s;
            s = '0;
            for (int b = 0; b < BLOCKS; b++) begin
                if ($urandom_range(0, 3) == 0) s[3*b +: 3] = 3'($urandom_range(1, 7));
            end
            syndrome = s;
            counter = {$urandom, $urandom};
            error_detected = ($urandom_range(0, 9) < 4);
            enable = ($urandom_range(0, 9) < 2);
            ev_ready = ($urandom_range(0, 9) < 3);
            clr_stats = ($urandom_range(0, 149) == 0);
            step();
        end
        error_detected = 1'b0;
        clr_stats = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
